// File: rtl/npu_lane_buffer.sv
// npu_lane_buffer: circular staging buffer that streams packed words out as LANES parallel lanes.
// Optional replay mode (re-stream stored words without consuming them) under NPU_LANE_BUFFER_REPLAY_EN.
module npu_lane_buffer #(
  parameter  int LANES  = 4,
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int WORD_W = LANES * DATA_W,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic              write,
  input  logic              read,
  input  logic [1:0]        address,
  input  logic [WORD_W-1:0] writedata,
  output logic [31:0]       readdata,
  input  logic              reading,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] data_out,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_overflow;
  logic              r_out_valid;
  logic [WORD_W-1:0] r_data_out;
  logic [31:0]       r_readdata;

  logic              w_replay;
  logic              w_push_req;
  logic              w_ctrl_wr;
  logic              w_soft_clr;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_load;
  logic              w_consume;
  logic [AW-1:0]     w_load_addr;
  logic [AW-1:0]     w_rd_ptr_nxt;
  logic [31:0]       w_rd_mux;

  // full/empty come from the pre-edge count, so a push to a full buffer loses even if a load frees a slot.
  assign w_full       = (r_count == (AW+1)'(DEPTH));
  assign w_empty      = (r_count == (AW+1)'(0));
  assign w_push_req   = chipselect && write && (address == 2'd0);
  assign w_ctrl_wr    = chipselect && write && (address == 2'd1);
  assign w_soft_clr   = w_ctrl_wr && writedata[0];
  assign w_push       = w_push_req && !w_full && !w_replay;
  assign w_load       = reading && !w_empty && (!r_out_valid || out_ready);
  assign w_consume    = w_load && !w_replay;
  assign w_rd_ptr_nxt = w_consume ? (r_rd_ptr + AW'(1)) : r_rd_ptr;

`ifdef NPU_LANE_BUFFER_REPLAY_EN
  logic          r_replay;
  logic [AW-1:0] r_rp;
  logic [AW-1:0] r_idx;
  logic          w_wrap;

  assign w_replay    = r_replay;
  assign w_wrap      = ({1'b0, r_idx} == (r_count - (AW+1)'(1)));
  assign w_load_addr = r_replay ? r_rp : r_rd_ptr;

  // Replay cursor walks the stored window starting at rd_ptr and wraps after count entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_replay <= 1'b0;
      r_rp     <= '0;
      r_idx    <= '0;
    end else if (w_soft_clr) begin
      r_replay <= writedata[1];
      r_rp     <= '0;
      r_idx    <= '0;
    end else begin
      if (w_ctrl_wr) begin
        r_replay <= writedata[1];
      end
      if (w_ctrl_wr && writedata[1] && !r_replay) begin
        r_rp  <= w_rd_ptr_nxt;
        r_idx <= '0;
      end else if (r_replay && w_load) begin
        if (w_wrap) begin
          r_rp  <= r_rd_ptr;
          r_idx <= '0;
        end else begin
          r_rp  <= r_rp + AW'(1);
          r_idx <= r_idx + AW'(1);
        end
      end
    end
  end
`else
  assign w_replay    = 1'b0;
  assign w_load_addr = r_rd_ptr;
`endif

  // Storage array: written only on accepted pushes, so contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= writedata;
    end
  end

  // Pointers, occupancy, sticky overflow and the lane output register.
  always_ff @(posedge clk) begin
    if (reset || w_soft_clr) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
      r_data_out  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr <= w_rd_ptr_nxt;
      case ({w_push, w_consume})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_push_req && (w_full || w_replay)) begin
        r_overflow <= 1'b1;
      end
      if (w_load) begin
        r_data_out  <= r_mem[w_load_addr];
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Status word; other addresses read as zero.
  always_comb begin
    w_rd_mux = 32'd0;
    case (address)
      2'd2:    w_rd_mux = {14'd0, w_replay, r_overflow, 16'(r_count)};
      default: w_rd_mux = 32'd0;
    endcase
  end

  // readdata updates only on a read strobe and holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_readdata <= 32'd0;
    end else if (chipselect && read) begin
      r_readdata <= w_rd_mux;
    end
  end

  assign readdata  = r_readdata;
  assign out_valid = r_out_valid;
  assign data_out  = r_data_out;
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = w_empty;

endmodule

// File: tb/tb_npu_lane_buffer.sv
// Testbench for npu_lane_buffer: queue-based reference model checked every cycle, a vector table,
// hand-written corner sequences and randomized traffic. Replay expectations follow NPU_LANE_BUFFER_REPLAY_EN.
module tb_npu_lane_buffer;
  localparam int LANES  = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
`ifdef NPU_LANE_BUFFER_REPLAY_EN
  localparam bit REPLAY = 1'b1;
`else
  localparam bit REPLAY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0, write = 1'b0, read = 1'b0;
  logic [1:0]  address = 2'd0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        reading = 1'b0, out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] data_out;
  logic [2:0]  count;
  logic        full, empty;

  always #5 clk = ~clk;

  npu_lane_buffer #(.LANES(LANES), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata), .reading(reading),
    .out_ready(out_ready), .out_valid(out_valid), .data_out(data_out), .count(count),
    .full(full), .empty(empty)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the stored words are a queue whose front is the next word to consume.
  logic [31:0] m_q[$];
  logic        m_ov = 1'b0, m_over = 1'b0, m_rep = 1'b0;
  logic [31:0] m_do = 32'd0, m_rd = 32'd0;
  int          m_ridx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit push, ctrl, ld;
    int n;
    if (reset) begin
      m_q.delete(); m_ov = 1'b0; m_do = 32'd0; m_over = 1'b0; m_rep = 1'b0; m_rd = 32'd0; m_ridx = 0;
      return;
    end
    n    = m_q.size();
    push = chipselect && write && (address == 2'd0);
    ctrl = chipselect && write && (address == 2'd1);
    ld   = reading && (n != 0) && (!m_ov || out_ready);
    if (chipselect && read) m_rd = (address == 2'd2) ? {14'd0, m_rep, m_over, 16'(n)} : 32'd0;
    if (ctrl && writedata[0]) begin
      m_q.delete(); m_ov = 1'b0; m_do = 32'd0; m_over = 1'b0; m_ridx = 0;
    end else begin
      if (ld) begin
        if (m_rep) begin
          m_do   = m_q[m_ridx];
          m_ridx = (m_ridx == n - 1) ? 0 : m_ridx + 1;
        end else begin
          m_do = m_q.pop_front();
        end
        m_ov = 1'b1;
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
      if (push) begin
        if (n == DEPTH || m_rep) m_over = 1'b1;
        else m_q.push_back(writedata);
      end
    end
    if (ctrl) begin
      if (REPLAY && writedata[1] && !m_rep) m_ridx = 0;
      m_rep = REPLAY && writedata[1];
    end
  endtask

  // One clock: advance the model with the inputs in force, then compare every output.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("data_out", data_out, m_do);
    check("count", 32'(count), 32'(m_q.size()));
    check("full", 32'(full), 32'(m_q.size() == DEPTH));
    check("empty", 32'(empty), 32'(m_q.size() == 0));
    check("readdata", readdata, m_rd);
  endtask

  task automatic idle();
    chipselect = 1'b0; write = 1'b0; read = 1'b0; address = 2'd0; writedata = 32'd0;
  endtask

  task automatic do_reset();
    idle(); reading = 1'b0; out_ready = 1'b0; reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [31:0] w);
    chipselect = 1'b1; write = 1'b1; address = 2'd0; writedata = w;
    tick(); idle();
  endtask

  task automatic ctrl_wr(input logic [31:0] v);
    chipselect = 1'b1; write = 1'b1; address = 2'd1; writedata = v;
    tick(); idle();
  endtask

  task automatic status_rd();
    chipselect = 1'b1; read = 1'b1; address = 2'd2;
    tick(); idle();
  endtask

  typedef struct {
    logic        cs, wr, rd;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic        rdg;
    logic        vld;
    logic [31:0] dat;
    int          cnt;
    logic        ful;
    logic [31:0] rdd;
  } vec_t;

  vec_t tbl[11];
  logic [31:0] seq[3];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data_out", data_out, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_readdata", readdata, 32'd0);

    // Scenario 1: first word latency and lane order
    reading = 1'b1; out_ready = 1'b1;
    push(32'h0F00_0133);
    check("s1_no_bypass", 32'(out_valid), 32'd0);
    tick();
    check("s1_valid", 32'(out_valid), 32'd1);
    check("s1_lane0", 32'(data_out[7:0]), 32'h33);
    check("s1_lane1", 32'(data_out[15:8]), 32'h01);
    check("s1_lane2", 32'(data_out[23:16]), 32'h00);
    check("s1_lane3", 32'(data_out[31:24]), 32'h0F);
    check("s1_empty", 32'(empty), 32'd1);
    check("s1_count", 32'(count), 32'd0);
    tick();
    check("s1_drained", 32'(out_valid), 32'd0);

    // Scenario 2: fill, overflow, status, then stream (vector table)
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++)
      tbl[i] = '{1'b1, 1'b1, 1'b0, 2'd0, 32'(i + 1), 1'b0, 1'b0, 32'd0, (i < 4) ? i + 1 : 4, (i >= 3), 32'd0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 2'd2, 32'd0, 1'b0, 1'b0, 32'd0, 4, 1'b1, 32'h0001_0004};
    for (int i = 0; i < 4; i++)
      tbl[6 + i] = '{1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b1, 32'(i + 1), 3 - i, 1'b0, 32'h0001_0004};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 32'd4, 0, 1'b0, 32'h0001_0004};
    for (int i = 0; i < 11; i++) begin
      chipselect = tbl[i].cs; write = tbl[i].wr; read = tbl[i].rd;
      address = tbl[i].addr; writedata = tbl[i].wd; reading = tbl[i].rdg;
      tick();
      check($sformatf("s2_v%0d_valid", i), 32'(out_valid), 32'(tbl[i].vld));
      check($sformatf("s2_v%0d_data", i), data_out, tbl[i].dat);
      check($sformatf("s2_v%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      check($sformatf("s2_v%0d_full", i), 32'(full), 32'(tbl[i].ful));
      check($sformatf("s2_v%0d_rdata", i), readdata, tbl[i].rdd);
    end
    idle();

    // Scenario 3: backpressure holds the word stable
    do_reset();
    push(32'hAAAA_0001);
    push(32'hBBBB_0002);
    reading = 1'b1;
    tick();
    check("s3_first", data_out, 32'hAAAA_0001);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("s3_hold_valid", 32'(out_valid), 32'd1);
      check("s3_hold_data", data_out, 32'hAAAA_0001);
      check("s3_hold_count", 32'(count), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("s3_w1_accept", data_out, 32'hAAAA_0001);
    tick();
    check("s3_w2", data_out, 32'hBBBB_0002);
    check("s3_w2_valid", 32'(out_valid), 32'd1);
    tick();
    check("s3_done", 32'(out_valid), 32'd0);

    // Scenario 4: push to a full buffer at the same edge as a load
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(32'h10 + 32'(i));
    check("s4_full", 32'(full), 32'd1);
    reading = 1'b1;
    chipselect = 1'b1; write = 1'b1; address = 2'd0; writedata = 32'h99;
    tick(); idle();
    reading = 1'b0;
    check("s4_count", 32'(count), 32'd3);
    check("s4_data", data_out, 32'h10);
    status_rd();
    check("s4_status", readdata, 32'h0001_0003);
    reading = 1'b1;
    repeat (4) tick();

    // Scenario 5: soft clear while streaming
    do_reset();
    out_ready = 1'b1;
    push(32'h21); push(32'h22); push(32'h23);
    status_rd();
    check("s5_status_pre", readdata, 32'h0000_0003);
    reading = 1'b1;
    tick();
    ctrl_wr(32'h1);
    check("s5_count", 32'(count), 32'd0);
    check("s5_empty", 32'(empty), 32'd1);
    check("s5_valid", 32'(out_valid), 32'd0);
    check("s5_data", data_out, 32'd0);
    reading = 1'b0;
    status_rd();
    check("s5_status", readdata, 32'd0);

    // Scenario 6: replay control
    do_reset();
    seq[0] = 32'hA0A0_000A; seq[1] = 32'hB0B0_000B; seq[2] = 32'hC0C0_000C;
    for (int i = 0; i < 3; i++) push(seq[i]);
    ctrl_wr(32'h2);
    reading = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
`ifdef NPU_LANE_BUFFER_REPLAY_EN
      check("s6_rp_valid", 32'(out_valid), 32'd1);
      check("s6_rp_data", data_out, seq[i % 3]);
      check("s6_rp_count", 32'(count), 32'd3);
`else
      if (i < 3) begin
        check("s6_nrm_data", data_out, seq[i]);
        check("s6_nrm_count", 32'(count), 32'(2 - i));
      end else begin
        check("s6_nrm_valid", 32'(out_valid), 32'd0);
      end
`endif
    end
    reading = 1'b0;
    push(32'hD0D0_000D);
    status_rd();
`ifdef NPU_LANE_BUFFER_REPLAY_EN
    check("s6_rp_status", readdata, 32'h0003_0003);
`else
    check("s6_nrm_status", readdata, 32'h0000_0001);
`endif
    ctrl_wr(32'h0);

    // Randomized traffic with a mid-stream reset
    do_reset();
    for (int i = 0; i < 900; i++) begin
      int r;
      r = $urandom_range(0, 99);
      address    = (r < 60) ? 2'd0 : (r < 62) ? 2'd1 : (r < 90) ? 2'd2 : 2'd3;
      chipselect = ($urandom_range(0, 7) != 0);
      write      = $urandom_range(0, 1) != 0;
      read       = $urandom_range(0, 1) != 0;
      writedata  = $urandom;
      reading    = ($urandom_range(0, 99) < ((i < 450) ? 30 : 85));
      out_ready  = ($urandom_range(0, 99) < 70);
      reset      = (i == 600);
      tick();
      if (i == 600) begin
        check("rnd_reset_valid", 32'(out_valid), 32'd0);
        check("rnd_reset_count", 32'(count), 32'd0);
      end
    end
    reset = 1'b0;
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
